// File: rtl/cpu_debug_ctrl.sv
// Host-side cpu debug controller: button-driven PAUSE/STEP, 16-register dumps, memory-write capture.
// Optional build macro DBG_AUTODUMP_EN: dumps also start on PAUSE 0->1 and after each STEP pulse.

module cpu_debug_ctrl #(
  parameter int NREGS         = 16,
  parameter int STEP_CYCLES   = 4,
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        btn_pause,
  input  logic        btn_step,
  input  logic        btn_dump,
  input  logic [3:0]  dbg_sel,
  output logic        PAUSE,
  output logic        STEP,
  output logic        cpuin_regfile_request,
  output logic [3:0]  cpuin_regfile_ra,
  input  logic        cpuout_regfile_grant,
  input  logic [15:0] cpuout_regfile_rd,
  input  logic        cpuout_memupdate,
  input  logic [7:0]  cpuout_memaddr,
  input  logic [15:0] cpuout_memdata,
  output logic [15:0] snap_data,
  output logic        snap_valid,
  output logic        dump_busy,
  output logic        dump_err,
  output logic [7:0]  last_memaddr,
  output logic [15:0] last_memdata,
  output logic [7:0]  mem_wr_count
);

  localparam logic [3:0] LAST_IDX  = 4'(NREGS - 1);
  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES - 1);
  localparam logic [7:0] TMO_LAST  = 8'(GRANT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} dump_state_t;

  logic [2:0]  pause_sync;
  logic [2:0]  step_sync;
  logic [2:0]  dump_sync;
  logic        pause_rise;
  logic        step_rise;
  logic        dump_rise;
  logic        dump_start;
  logic [7:0]  step_cnt;
  dump_state_t state;
  dump_state_t next_state;
  logic [3:0]  idx;
  logic [7:0]  tmo_cnt;
  logic [15:0] snapshot [NREGS];
  logic        mem_prev;

  // Two synchronizer flops per button, third flop gives the previous level for edge detect.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pause_sync <= '0;
      step_sync  <= '0;
      dump_sync  <= '0;
    end else begin
      pause_sync <= {pause_sync[1:0], btn_pause};
      step_sync  <= {step_sync[1:0], btn_step};
      dump_sync  <= {dump_sync[1:0], btn_dump};
    end
  end

  assign pause_rise = pause_sync[1] & ~pause_sync[2];
  assign step_rise  = step_sync[1] & ~step_sync[2];
  assign dump_rise  = dump_sync[1] & ~dump_sync[2];

  // step_cnt holds the remaining high cycles after the current one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PAUSE    <= 1'b0;
      STEP     <= 1'b0;
      step_cnt <= '0;
    end else begin
      if (pause_rise) PAUSE <= ~PAUSE;
      if (pause_rise && PAUSE && STEP) begin
        STEP     <= 1'b0;
        step_cnt <= '0;
      end else if (STEP) begin
        if (step_cnt == 8'd0) STEP <= 1'b0;
        else step_cnt <= step_cnt - 8'd1;
      end else if (step_rise && PAUSE && !pause_rise) begin
        STEP     <= 1'b1;
        step_cnt <= STEP_LOAD;
      end
    end
  end

`ifdef DBG_AUTODUMP_EN
  logic step_q;
  logic auto_start;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) step_q <= 1'b0;
    else step_q <= STEP;
  end

  assign auto_start = (pause_rise & ~PAUSE) | (step_q & ~STEP);
  assign dump_start = dump_rise | auto_start;
`else
  assign dump_start = dump_rise;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (dump_start) next_state = REQ;
      REQ: begin
        if (cpuout_regfile_grant) next_state = GAP;
        else if (tmo_cnt == TMO_LAST) next_state = IDLE;
      end
      GAP:     next_state = (idx == LAST_IDX) ? DONE : REQ;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Dump datapath; a timeout leaves snap_valid low so a partial snapshot is never advertised.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx        <= '0;
      tmo_cnt    <= '0;
      snap_valid <= 1'b0;
      dump_err   <= 1'b0;
      for (int i = 0; i < NREGS; i++) snapshot[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dump_start) begin
            idx        <= '0;
            tmo_cnt    <= '0;
            snap_valid <= 1'b0;
            dump_err   <= 1'b0;
          end
        end
        REQ: begin
          if (cpuout_regfile_grant) snapshot[idx] <= cpuout_regfile_rd;
          else if (tmo_cnt == TMO_LAST) dump_err <= 1'b1;
          else tmo_cnt <= tmo_cnt + 8'd1;
        end
        GAP: begin
          tmo_cnt <= '0;
          if (idx != LAST_IDX) idx <= idx + 4'd1;
        end
        DONE:    snap_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  assign cpuin_regfile_request = (state == REQ);
  assign cpuin_regfile_ra      = idx;
  assign dump_busy             = (state != IDLE);
  assign snap_data             = snapshot[dbg_sel];

  // Memory writes are captured on the rising edge of memupdate only, whatever the debug state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem_prev     <= 1'b0;
      last_memaddr <= '0;
      last_memdata <= '0;
      mem_wr_count <= '0;
    end else begin
      mem_prev <= cpuout_memupdate;
      if (cpuout_memupdate && !mem_prev) begin
        last_memaddr <= cpuout_memaddr;
        last_memdata <= cpuout_memdata;
        mem_wr_count <= mem_wr_count + 8'd1;
      end
    end
  end

endmodule
